// File: rtl/ctrl_fsm_if.sv
// Memory request/acknowledge bundle between ctrl_fsm (master) and the memory side (slave).
// Also supplies `WORDSIZE and the `EXTNR_* extender codes when defs.v is not part of the build.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif
`ifndef EXTNR_R
`define EXTNR_R 2'd0
`endif
`ifndef EXTNR_I
`define EXTNR_I 2'd1
`endif
`ifndef EXTNR_S
`define EXTNR_S 2'd2
`endif
`ifndef EXTNR_B
`define EXTNR_B 2'd3
`endif

interface ctrl_fsm_if;
   logic mem_req;
   logic mem_we;
   logic mem_ack;

   modport master (output mem_req, output mem_we, input mem_ack);
   modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back, sticky fault.
// Optional CTRL_INSTRET_EN adds a 32-bit retired-instruction counter output (instret).
//
// state    | code | meaning
// S_FETCH  | 0    | request instruction word, latch ir on ack
// S_DECODE | 1    | classify opcode, illegal -> fault
// S_EXEC   | 2    | branches retire here, others go to MEM or WB
// S_MEM    | 3    | load/store data access, stores retire on ack
// S_WB     | 4    | register write-back and PC update
// S_FAULT  | 7    | sticky fault, left only through rst
`ifndef WORDSIZE
`define WORDSIZE 32
`endif
`ifndef EXTNR_R
`define EXTNR_R 2'd0
`endif
`ifndef EXTNR_I
`define EXTNR_I 2'd1
`endif
`ifndef EXTNR_S
`define EXTNR_S 2'd2
`endif
`ifndef EXTNR_B
`define EXTNR_B 2'd3
`endif

module ctrl_fsm #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [`WORDSIZE-1:0] ir,
   input  logic                 br_taken,
   ctrl_fsm_if.master           mem,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 reg_we,
   output logic                 pc_sel,
   output logic [1:0]           extnr_ops,
   output logic                 alu_src,
   output logic [1:0]           wb_sel,
   output logic [2:0]           state,
   output logic                 fault
`ifdef CTRL_INSTRET_EN
   ,
   output logic [31:0]          instret
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_ILL
   } op_t;

   localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_WAIT_MAX - 1);

   state_t        state_q, state_nxt;
   op_t           op;
   logic [CW-1:0] wait_cnt;
   logic          wait_tc;
   logic          mem_req_c, mem_we_c;
   logic          ir_we_c, pc_we_c, reg_we_c, pc_sel_c;
   logic          unused_ir;

   assign unused_ir = ^ir[`WORDSIZE-1:12];

   always_comb begin
      case (ir[6:0])
         7'b0110011: op = OP_R;
         7'b0010011: op = OP_I;
         7'b0000011: op = OP_LOAD;
         7'b0100011: op = OP_STORE;
         7'b1100011: op = OP_BRANCH;
         7'b1100111: op = OP_JALR;
         default:    op = OP_ILL;
      endcase
   end

   always_comb begin
      case (op)
         OP_I, OP_LOAD, OP_JALR: extnr_ops = `EXTNR_I;
         OP_STORE:               extnr_ops = `EXTNR_S;
         OP_BRANCH:              extnr_ops = `EXTNR_B;
         default:                extnr_ops = `EXTNR_R;
      endcase
   end

   assign alu_src = !(op == OP_R || op == OP_BRANCH);
   assign wb_sel  = (op == OP_LOAD) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
   assign wait_tc = (wait_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      ir_we_c   = 1'b0;
      pc_we_c   = 1'b0;
      reg_we_c  = 1'b0;
      pc_sel_c  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (mem.mem_ack) begin
               ir_we_c   = 1'b1;
               state_nxt = S_DECODE;
            end else if (wait_tc) begin
               state_nxt = S_FAULT;
            end
         end
         S_DECODE: state_nxt = (op == OP_ILL) ? S_FAULT : S_EXEC;
         S_EXEC: begin
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEM;
               OP_BRANCH: begin
                  pc_we_c   = 1'b1;
                  pc_sel_c  = br_taken;
                  state_nxt = S_FETCH;
               end
               OP_ILL:  state_nxt = S_FAULT;
               default: state_nxt = S_WB;
            endcase
         end
         S_MEM: begin
            mem_req_c = 1'b1;
            mem_we_c  = (op == OP_STORE);
            if (mem.mem_ack) begin
               if (op == OP_STORE) begin
                  pc_we_c   = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (wait_tc) begin
               state_nxt = S_FAULT;
            end
         end
         S_WB: begin
            reg_we_c  = (ir[11:7] != 5'd0);
            pc_we_c   = 1'b1;
            pc_sel_c  = (op == OP_JALR);
            state_nxt = S_FETCH;
         end
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_FAULT;
      endcase
   end

   // Timeout down-counter reloads on any state change or ack, so each wait starts fresh.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= WAIT_LOAD;
      else if (state_nxt != state_q || (mem_req_c && mem.mem_ack))
         wait_cnt <= WAIT_LOAD;
      else if (mem_req_c && !wait_tc)
         wait_cnt <= wait_cnt - 1'b1;
   end

   // Reset is synchronous, so outputs are masked combinationally while rst is high.
   assign mem.mem_req = mem_req_c & ~rst;
   assign mem.mem_we  = mem_we_c  & ~rst;
   assign ir_we       = ir_we_c   & ~rst;
   assign pc_we       = pc_we_c   & ~rst;
   assign reg_we      = reg_we_c  & ~rst;
   assign pc_sel      = pc_sel_c  & ~rst;
   assign state       = rst ? 3'd0 : state_q;
   assign fault       = ~rst & (state_q == S_FAULT);

`ifdef CTRL_INSTRET_EN
   always_ff @(posedge clk) begin
      if (rst)        instret <= 32'd0;
      else if (pc_we) instret <= instret + 32'd1;
   end
`endif

endmodule
